// File: rtl/clk_prescaler_ctrl.sv
// CPU clock prescaler sequencer: ROM-driven down-counter producing a tick
// and a divided clock, with run/halt, single-step and rate-change handshake.
module clk_prescaler_ctrl #(
    parameter int          CNT_W     = 24,
    parameter int          IDX_W     = 4,
    parameter int unsigned RESET_IDX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_valid,
    input  logic [IDX_W-1:0] sel_idx,
    output logic             sel_ready,
    output logic [IDX_W-1:0] rom_ad,
    input  logic [CNT_W-1:0] rom_dout,
    input  logic             run,
    input  logic             step,
    output logic             clk_en,
    output logic             clk_div,
    output logic [IDX_W-1:0] cur_idx
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] reload, reload_d;
    logic [IDX_W-1:0] cur_d;
    logic [IDX_W-1:0] pend_idx, pend_idx_d;
    logic             pend_vld, pend_vld_d;
    logic             en_d, div_d;
    logic             accept, have_req;
    logic [IDX_W-1:0] req_idx;

    assign sel_ready = (state != LOAD) && !pend_vld;
    assign accept    = sel_valid && sel_ready;
    assign rom_ad    = cur_idx;

    // A request accepted this very cycle counts as pending.
    assign have_req = pend_vld || accept;
    assign req_idx  = pend_vld ? pend_idx : sel_idx;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        reload_d   = reload;
        cur_d      = cur_idx;
        pend_idx_d = pend_idx;
        pend_vld_d = pend_vld;
        en_d       = 1'b0;
        div_d      = clk_div;

        if (accept) begin
            pend_idx_d = sel_idx;
            pend_vld_d = 1'b1;
        end

        unique case (state)
            LOAD: begin
                reload_d   = rom_dout;
                cnt_d      = rom_dout;
                pend_vld_d = 1'b0;
                state_d    = run ? RUN : HALT;
            end
            RUN: begin
                if (!run) begin
                    state_d = HALT;
                end else if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    en_d  = 1'b1;
                    div_d = ~clk_div;
                    if (have_req) begin
                        cur_d   = req_idx;
                        state_d = LOAD;
                    end else begin
                        cnt_d = reload;
                    end
                end
            end
            HALT: begin
                if (have_req) begin
                    cur_d   = req_idx;
                    state_d = LOAD;
                end else if (step) begin
                    en_d  = 1'b1;
                    div_d = ~clk_div;
                    cnt_d = reload;
                end else if (run) begin
                    state_d = RUN;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD;
            cnt      <= '0;
            reload   <= '0;
            cur_idx  <= IDX_W'(RESET_IDX);
            pend_idx <= '0;
            pend_vld <= 1'b0;
            clk_en   <= 1'b0;
            clk_div  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            reload   <= reload_d;
            cur_idx  <= cur_d;
            pend_idx <= pend_idx_d;
            pend_vld <= pend_vld_d;
            clk_en   <= en_d;
            clk_div  <= div_d;
        end
    end

endmodule

// File: tb/tb_clk_prescaler_ctrl.sv
// Directed bench for clk_prescaler_ctrl: one instance on index 0, one on
// index 15 driven through rate changes, halt/step and reset.
module tb_clk_prescaler_ctrl;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        run_b, step_b, sv_b;
    logic [3:0]  si_b;
    logic        sv_a = 1'b0, run_a = 1'b1, step_a = 1'b0;
    logic [3:0]  si_a = 4'd0;

    logic        sr_a, en_a, div_a, sr_b, en_b, div_b;
    logic [3:0]  ad_a, ci_a, ad_b, ci_b;
    logic [23:0] rd_a, rd_b;

    int ncmp = 0;
    int nfail = 0;
    int n;
    logic exp_div;
    logic ediv;

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_f(input logic [3:0] a);
        case (a)
            4'd0:    rom_f = 24'd0;
            4'd3:    rom_f = 24'd4;
            4'd5:    rom_f = 24'd9;
            4'd7:    rom_f = 24'd2;
            4'd15:   rom_f = 24'hCDFE5F;
            default: rom_f = 24'd20;
        endcase
    endfunction

    assign rd_a = rom_f(ad_a);
    assign rd_b = rom_f(ad_b);

    clk_prescaler_ctrl #(.RESET_IDX(0)) u_a (
        .clk(clk), .rst_n(rst_a),
        .sel_valid(sv_a), .sel_idx(si_a), .sel_ready(sr_a),
        .rom_ad(ad_a), .rom_dout(rd_a),
        .run(run_a), .step(step_a),
        .clk_en(en_a), .clk_div(div_a), .cur_idx(ci_a)
    );

    clk_prescaler_ctrl u_b (
        .clk(clk), .rst_n(rst_b),
        .sel_valid(sv_b), .sel_idx(si_b), .sel_ready(sr_b),
        .rom_ad(ad_b), .rom_dout(rd_b),
        .run(run_b), .step(step_b),
        .clk_en(en_b), .clk_div(div_b), .cur_idx(ci_b)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles until the next tick of u_b; clk_div must hold meanwhile.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
            if (!en_b) chk("b_div_hold", 32'(div_b), 32'(exp_div));
        end while (!en_b && cnt < 40);
        if (!en_b) chk("b_tick_timeout", 32'(en_b), 32'd1);
        exp_div = ~exp_div;
        chk("b_div_tog", 32'(div_b), 32'(exp_div));
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        run_b = 1'b0; step_b = 1'b0; sv_b = 1'b0; si_b = 4'd0;
        exp_div = 1'b0;
        cyc(); cyc();

        // Instance A: production index 0
        chk("a_rst_en", 32'(en_a), 32'd0);
        chk("a_rst_div", 32'(div_a), 32'd0);
        chk("a_rst_idx", 32'(ci_a), 32'd0);
        chk("a_rst_ad", 32'(ad_a), 32'd0);
        rst_a = 1'b1;
        cyc();
        chk("a_c1_en", 32'(en_a), 32'd0);
        ediv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            ediv = ~ediv;
            chk("a_tick", 32'(en_a), 32'd1);
            chk("a_div", 32'(div_a), 32'(ediv));
        end

        // Instance B: reset state, then LOAD of entry 15 into HALT
        chk("b_rst_en", 32'(en_b), 32'd0);
        chk("b_rst_div", 32'(div_b), 32'd0);
        chk("b_rst_idx", 32'(ci_b), 32'd15);
        chk("b_rst_ad", 32'(ad_b), 32'd15);
        chk("b_rst_rdy", 32'(sr_b), 32'd0);
        rst_b = 1'b1;
        cyc();
        chk("b_reload15", 32'(u_b.reload), 32'hCDFE5F);
        chk("b_halt_rdy", 32'(sr_b), 32'd1);
        chk("b_halt_en", 32'(en_b), 32'd0);

        // Select idx 3 from HALT, then run
        sv_b = 1'b1; si_b = 4'd3;
        cyc();
        chk("b_acc_rdy", 32'(sr_b), 32'd0);
        chk("b_acc_idx", 32'(ci_b), 32'd3);
        chk("b_acc_en", 32'(en_b), 32'd0);
        sv_b = 1'b0; run_b = 1'b1;
        cyc();
        chk("b_ld_rdy", 32'(sr_b), 32'd1);
        chk("b_ld_cnt", 32'(u_b.cnt), 32'd4);
        wait_tick(n);
        chk("b_first", 32'(n), 32'd5);
        wait_tick(n);
        chk("b_per", 32'(n), 32'd5);

        // Rate change to idx 5 mid-count
        cyc();
        chk("b_rdy_pre", 32'(sr_b), 32'd1);
        sv_b = 1'b1; si_b = 4'd5;
        cyc();
        chk("b_rdy_acc", 32'(sr_b), 32'd0);
        si_b = 4'd7;
        cyc();
        chk("b_rdy_pend", 32'(sr_b), 32'd0);
        sv_b = 1'b0;
        wait_tick(n);
        chk("b_sched", 32'(n), 32'd2);
        chk("b_chg_idx", 32'(ci_b), 32'd5);
        chk("b_ld_rdy2", 32'(sr_b), 32'd0);
        cyc();
        chk("b_rdy_back", 32'(sr_b), 32'd1);
        chk("b_chg_cnt", 32'(u_b.cnt), 32'd9);
        wait_tick(n);
        chk("b_bound", 32'(n), 32'd10);
        wait_tick(n);
        chk("b_newper", 32'(n), 32'd10);
        chk("b_idx_not7", 32'(ci_b), 32'd5);

        // Halt mid-count, two steps, resume
        cyc(); cyc(); cyc();
        run_b = 1'b0;
        cyc();
        chk("b_frz_cnt", 32'(u_b.cnt), 32'd6);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("b_halt_en", 32'(en_b), 32'd0);
            chk("b_frz", 32'(u_b.cnt), 32'd6);
        end
        step_b = 1'b1;
        cyc();
        exp_div = ~exp_div;
        chk("b_step1_en", 32'(en_b), 32'd1);
        chk("b_step1_div", 32'(div_b), 32'(exp_div));
        chk("b_step_cnt", 32'(u_b.cnt), 32'd9);
        cyc();
        exp_div = ~exp_div;
        chk("b_step2_en", 32'(en_b), 32'd1);
        chk("b_step2_div", 32'(div_b), 32'(exp_div));
        step_b = 1'b0;
        cyc();
        chk("b_step_end", 32'(en_b), 32'd0);
        cyc();
        chk("b_step_end2", 32'(en_b), 32'd0);
        chk("b_step_cnt2", 32'(u_b.cnt), 32'd9);
        run_b = 1'b1;
        wait_tick(n);
        chk("b_resume", 32'(n), 32'd11);

        // Accept on the cnt = 0 cycle
        for (int i = 0; i < 9; i++) cyc();
        chk("b_cnt0", 32'(u_b.cnt), 32'd0);
        chk("b_cnt0_rdy", 32'(sr_b), 32'd1);
        sv_b = 1'b1; si_b = 4'd3;
        cyc();
        sv_b = 1'b0;
        exp_div = ~exp_div;
        chk("b_coinc_en", 32'(en_b), 32'd1);
        chk("b_coinc_div", 32'(div_b), 32'(exp_div));
        chk("b_coinc_idx", 32'(ci_b), 32'd3);
        chk("b_coinc_rdy", 32'(sr_b), 32'd0);
        wait_tick(n);
        chk("b_coinc_next", 32'(n), 32'd6);

        // Request and step together in HALT
        run_b = 1'b0;
        cyc();
        sv_b = 1'b1; si_b = 4'd5; step_b = 1'b1;
        cyc();
        sv_b = 1'b0; step_b = 1'b0;
        chk("b_ls_en", 32'(en_b), 32'd0);
        chk("b_ls_idx", 32'(ci_b), 32'd5);
        chk("b_ls_div", 32'(div_b), 32'(exp_div));
        chk("b_ls_rdy", 32'(sr_b), 32'd0);
        cyc();
        chk("b_ls_reload", 32'(u_b.reload), 32'd9);
        chk("b_ls_en2", 32'(en_b), 32'd0);
        chk("b_ls_rdy2", 32'(sr_b), 32'd1);
        step_b = 1'b1;
        cyc();
        step_b = 1'b0;
        exp_div = ~exp_div;
        chk("b_step3_en", 32'(en_b), 32'd1);
        chk("b_step3_div", 32'(div_b), 32'(exp_div));

        // Reset with a request pending in RUN
        run_b = 1'b1;
        cyc();
        sv_b = 1'b1; si_b = 4'd3;
        cyc();
        sv_b = 1'b0;
        chk("b_pend", 32'(u_b.pend_vld), 32'd1);
        chk("b_pend_rdy", 32'(sr_b), 32'd0);
        rst_b = 1'b0;
        cyc();
        exp_div = 1'b0;
        chk("b_rst2_en", 32'(en_b), 32'd0);
        chk("b_rst2_div", 32'(div_b), 32'd0);
        chk("b_rst2_idx", 32'(ci_b), 32'd15);
        chk("b_rst2_ad", 32'(ad_b), 32'd15);
        chk("b_rst2_rdy", 32'(sr_b), 32'd0);
        chk("b_rst2_pend", 32'(u_b.pend_vld), 32'd0);
        rst_b = 1'b1; run_b = 1'b0;
        cyc();
        chk("b_post_idx", 32'(ci_b), 32'd15);
        chk("b_post_rdy", 32'(sr_b), 32'd1);
        chk("b_post_en", 32'(en_b), 32'd0);
        cyc();
        chk("b_post_en2", 32'(en_b), 32'd0);
        chk("b_post_idx2", 32'(ci_b), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/clk_prescaler_ctrl.md
# clk_prescaler_ctrl

Sequencer for the CPU clock prescaler. It owns the 16-entry × 24-bit divide-value ROM (`rom_ad`/`rom_dout`) and loads the selected terminal count into a down-counter. From that count it produces a one-cycle CPU clock-enable tick and a divided square wave. It also supports run/halt and single-step, and applies rate changes from a valid/ready requester only at tick boundaries.

## Interface
**Parameters**
- `CNT_W`, 24: counter width; must match the ROM word width.
- `IDX_W`, 4: ROM index width.
- `RESET_IDX`, 15: index selected at reset. In the production ROM, entry 15 = 24'hCDFE5F (13,499,999), which gives 1 Hz from 27 MHz.

**Ports**
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `sel_valid`, in, 1: rate-change request.
- `sel_idx`, in, IDX_W: requested ROM index.
- `sel_ready`, out, 1: request accepted when `sel_valid && sel_ready`.
- `rom_ad`, out, IDX_W: ROM address, registered.
- `rom_dout`, in, CNT_W: ROM data, combinational from `rom_ad`.
- `run`, in, 1: level. 1 = free-run, 0 = halt.
- `step`, in, 1: single-step pulse, honoured only in HALT.
- `clk_en`, out, 1: one-cycle tick, registered.
- `clk_div`, out, 1: toggles on every tick, registered.
- `cur_idx`, out, IDX_W: index currently in effect.

## Operation
**Registers**
- `cur_idx`
- `pend_idx` and `pend_vld`
- `reload` (CNT_W)
- `cnt` (CNT_W)
- `state` ∈ {LOAD, RUN, HALT}

`rom_ad` always equals `cur_idx`.

**Reset** (`rst_n` low at an edge; any state, pending request discarded):
- state = LOAD, `cur_idx` = `RESET_IDX`, `pend_vld` = 0
- `cnt` = 0, `reload` = 0
- `clk_en` = 0, `clk_div` = 0

**`sel_ready`** = (state ≠ LOAD) && !`pend_vld`.
- On accept: `pend_idx` ← `sel_idx`, `pend_vld` ← 1.
- `sel_valid` while `sel_ready` = 0 is ignored; the requester holds it.

**LOAD** (exactly 1 cycle):
- `reload` ← `rom_dout`, `cnt` ← `rom_dout`, `pend_vld` ← 0.
- Next state: RUN if `run`, else HALT.

**RUN**
- If `run` = 0: go to HALT. `cnt`, `clk_div` and `pend_vld` are held. No tick.
- Else if `cnt` ≠ 0: `cnt` ← `cnt` − 1.
- Else (`cnt` = 0), the tick cycle:
  - `clk_en` ← 1 and `clk_div` ← ~`clk_div`.
  - If a request is pending or accepted this same cycle: `cur_idx` ← that index and go to LOAD.
  - Otherwise `cnt` ← `reload`.
- `step` is ignored.

**HALT**
- If a request is pending or accepted: `cur_idx` ← index and go to LOAD. This takes priority over `step` and `run`.
- Else if `step`: `clk_en` ← 1, `clk_div` ← ~`clk_div`, `cnt` ← `reload`. Stay in HALT.
- Else if `run`: go to RUN, resuming from the held `cnt`.

**`clk_en`** is 0 in every cycle not described above.

**Arithmetic**
- Unsigned. `cnt` never underflows; 0 is the terminal state.
- N = 0 (production entry 0) gives a tick every RUN cycle, and `clk_div` toggles every cycle.
- Re-selecting the current index is legal. It still passes through LOAD and restarts the phase.

## Timing
- **Start-up:** reset released before edge 0 ⇒ LOAD during cycle 0. With `run` = 1, RUN starts at cycle 1 with `cnt` = N. The first `clk_en` is high in cycle N+2.
- **Steady RUN:** ticks are spaced N+1 cycles apart. `clk_div` period is 2(N+1).
- **Rate change in RUN:** the tick still occurs in cycle T. LOAD is cycle T, RUN resumes at T+1 with N′, and the next tick is at T+N′+2. That boundary interval is N′+2, one cycle longer than steady state.
- **Rate change in HALT:** the accept edge leads to LOAD on the next cycle, then HALT or RUN. No tick is produced.
- **Step:** `step` high in cycle t (HALT, nothing pending) gives `clk_en` high in cycle t+1 only. Back-to-back step pulses give back-to-back ticks.
- **`sel_ready`:** drops the cycle after an accept. It returns the cycle after the LOAD that consumes the request.
- **`run` falling:** the HALT transition takes one edge. A `cnt` = 0 observed on that same cycle does not tick.

## Test plan
1. **Reset and production index 0.** Reset with the production ROM model and `RESET_IDX` = 0, `run` = 1. Required: `clk_en` = 0 and `clk_div` = 0 during reset, `cur_idx` = 0, then `clk_en` high every cycle from cycle 2 and `clk_div` toggling every cycle.
2. **Steady period.** Bench ROM with idx 3 = 4. Required: `clk_en` pulses exactly 5 cycles apart and `clk_div` period is 10. With `RESET_IDX` = 15 on the production ROM, `reload` = 24'hCDFE5F after LOAD.
3. **Rate change mid-run.** Running idx 3 (N = 4); request idx 5 (N = 9) mid-count. Required: the current tick lands on schedule, the next tick comes 11 cycles later, then every 10. `sel_ready` is low from accept until after LOAD. A second `sel_valid` while pending is not accepted.
4. **Halt and step.** Drop `run` mid-count: `clk_en` stays 0 and `cnt` is frozen. Two `step` pulses give exactly two one-cycle ticks. Raising `run` resumes; the first tick arrives after the frozen count reaches 0 (N+1 cycles, because `step` reloaded `cnt`).
5. **Simultaneous events.**
   - Accept on the `cnt` = 0 cycle: the tick occurs and LOAD follows immediately.
   - In HALT, request plus `step` in the same cycle: LOAD wins and no tick is produced.
6. **Reset mid-operation.** Assert `rst_n` = 0 for one edge while a request is pending in RUN. Required: all outputs return to reset values, the pending request is lost, and `cur_idx` = `RESET_IDX`.
